// File: rtl/md_sched.sv
// Multiply/divide sequencer for the Execute stage: owns HI/LO, runs mult/div over a
// fixed cycle count and stalls the Decode->Execute register while Decode needs the unit.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] V1_E,
  input  logic [31:0] V2_E,
  input  logic        md_use_D,
  input  logic        rd_hi_E,
  output logic [31:0] HiLo_E,
  output logic        busy,
  output logic        stall_D,
  output logic        flush_E
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES) < 4) ? 4 : $clog2(MAX_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_ok;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_busy;
  logic        w_is_md_op;

  assign w_prod_s = $signed({{32{V1_E[31]}}, V1_E}) * $signed({{32{V2_E[31]}}, V2_E});
  assign w_prod_u = {32'd0, V1_E} * {32'd0, V2_E};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign w_div_signed = (md_op_E == OP_DIV);
  assign w_a_neg      = w_div_signed & V1_E[31];
  assign w_b_neg      = w_div_signed & V2_E[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - V1_E) : V1_E;
  assign w_b_mag      = w_b_neg ? (32'd0 - V2_E) : V2_E;
  assign w_b_safe     = (V2_E == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_is_md_op = (md_op_E[2] == 1'b0);

  assign busy    = w_busy;
  assign stall_D = md_use_D & (w_busy | (start_E & w_is_md_op));
  assign flush_E = stall_D;
  assign HiLo_E  = rd_hi_E ? r_hi : r_lo;

  // Sequencer: launch on an idle start, count down, commit pending HI/LO on the last edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= CNT_ZERO;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_E) begin
            case (md_op_E)
              OP_MULT: begin
                r_pend_hi <= w_prod_s[63:32];
                r_pend_lo <= w_prod_s[31:0];
                r_pend_ok <= 1'b1;
                r_cnt     <= MUL_LOAD;
                r_state   <= ST_MUL;
              end
              OP_MULTU: begin
                r_pend_hi <= w_prod_u[63:32];
                r_pend_lo <= w_prod_u[31:0];
                r_pend_ok <= 1'b1;
                r_cnt     <= MUL_LOAD;
                r_state   <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quot;
                r_pend_ok <= (V2_E != 32'd0);
                r_cnt     <= DIV_LOAD;
                r_state   <= ST_DIV;
              end
              OP_MTHI: r_hi <= V1_E;
              OP_MTLO: r_lo <= V1_E;
              default: r_state <= ST_IDLE;
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt == CNT_ZERO) begin
            if (r_pend_ok) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end else begin
              r_hi <= r_hi;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched against a behavioural HI/LO and timing model.
`timescale 1ns/1ps
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_E = 1'b0;
  logic [2:0]  md_op_E = 3'd0;
  logic [31:0] V1_E = 32'd0;
  logic [31:0] V2_E = 32'd0;
  logic        md_use_D = 1'b0;
  logic        rd_hi_E = 1'b0;
  logic [31:0] HiLo_E;
  logic        busy;
  logic        stall_D;
  logic        flush_E;

  typedef struct {
    bit          is_mt;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_from = 0;
  int          busy_until = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .md_op_E(md_op_E),
    .V1_E(V1_E), .V2_E(V2_E), .md_use_D(md_use_D), .rd_hi_E(rd_hi_E),
    .HiLo_E(HiLo_E), .busy(busy), .stall_D(stall_D), .flush_E(flush_E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of one op as {HI, LO}, straight from the instruction semantics.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = {hi, lo};
    case (op)
      3'd0: p = 64'(sa * sbv);
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: if (b != 32'd0) begin
        q = sa / sbv;
        r = sa % sbv;
        p = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 32'd0) p = {a % b, a / b};
      3'd4: p = {a, lo};
      3'd5: p = {hi, a};
      default: p = {hi, lo};
    endcase
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    md_use_D = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    while (cyc < busy_until) step();
    start_E = 1'b1;
    md_op_E = op;
    V1_E    = a;
    V2_E    = b;
    p = ref_md(op, a, b, m_hi, m_lo);
    if (op <= 3'd3) begin
      busy_from  = cyc + 1;
      busy_until = cyc + 1 + ((op <= 3'd1) ? MC : DC);
      sb.push_back('{1'b0, p[63:32], p[31:0]});
    end else if (op <= 3'd5) begin
      sb.push_back('{1'b1, p[63:32], p[31:0]});
    end
    m_hi = p[63:32];
    m_lo = p[31:0];
    step();
    start_E = 1'b0;
    md_op_E = 3'($urandom);
    V1_E    = $urandom;
    V2_E    = $urandom;
    if (op == 3'd4 || op == 3'd5) step();
  endtask

  // A start presented while busy must leave everything untouched.
  task automatic poke(input logic [2:0] op);
    start_E = 1'b1;
    md_op_E = op;
    V1_E    = $urandom;
    V2_E    = $urandom;
    step();
    start_E = 1'b0;
  endtask

  task automatic async_reset_check();
    #1 reset = 1'b0;
    #1;
    check("busy_in_reset", {31'd0, busy}, 32'd0);
    check("lo_in_reset", HiLo_E, 32'd0);
    rd_hi_E = 1'b1;
    #1;
    check("hi_in_reset", HiLo_E, 32'd0);
    rd_hi_E = 1'b0;
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    busy_from  = 0;
    busy_until = 0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin : monitor
    bit          prev_busy;
    bit          exp_b;
    bit          exp_s;
    int          wait_cnt;
    logic [31:0] hi_v;
    logic [31:0] lo_v;
    exp_t        e;
    prev_busy = 1'b0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        wait_cnt  = 0;
      end else begin
        exp_b = (cyc >= busy_from) && (cyc < busy_until);
        exp_s = md_use_D & (exp_b | (start_E & (md_op_E < 3'd4)));
        check("busy", {31'd0, busy}, {31'd0, exp_b});
        check("stall_D", {31'd0, stall_D}, {31'd0, exp_s});
        check("flush_E", {31'd0, flush_E}, {31'd0, exp_s});
        rd_hi_E = 1'b1;
        #1 hi_v = HiLo_E;
        rd_hi_E = 1'b0;
        #1 lo_v = HiLo_E;
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL commit: busy fell with HI=%h LO=%h but no result was required", hi_v, lo_v);
          end else begin
            e = sb.pop_front();
            check("commit_kind", {31'd0, e.is_mt}, 32'd0);
            check("HI", hi_v, e.hi);
            check("LO", lo_v, e.lo);
          end
          wait_cnt = 0;
        end else if (!busy && !start_E && sb.size() > 0 && sb[0].is_mt) begin
          e = sb.pop_front();
          check("HI_mt", hi_v, e.hi);
          check("LO_mt", lo_v, e.lo);
          wait_cnt = 0;
        end else if (sb.size() > 0) begin
          wait_cnt++;
          if (wait_cnt > 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no result after 40 cycles, required HI=%h LO=%h", sb[0].hi, sb[0].lo);
            void'(sb.pop_front());
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : driver
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    #3;
    check("busy_at_reset", {31'd0, busy}, 32'd0);
    check("lo_at_reset", HiLo_E, 32'd0);
    rd_hi_E = 1'b1;
    #1;
    check("hi_at_reset", HiLo_E, 32'd0);
    rd_hi_E = 1'b0;
    step();
    reset = 1'b1;
    step();

    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd4, 32'h1234_5678, 32'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'd100, 32'd7);
    issue(3'd2, 32'hFFFF_FF9C, 32'd7);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    poke(3'd4);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);

    issue(3'd2, 32'd1000, 32'd3);
    step();
    async_reset_check();
    issue(3'd0, 32'd12345, 32'd678);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
      issue(op, a, b);
      if (op <= 3'd3 && $urandom_range(0, 5) == 0) poke(3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) step();
    end

    for (int i = 0; i < 60 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
